// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game engine: LFSR-generated or player-recorded sequences, one-hot LED
// playback, per-input timeout and the control FSM in one block.
module jogo_sequencia_param #(
    parameter int unsigned NUM_BOTOES   = 4,
    parameter int unsigned PROFUNDIDADE = 16,
    parameter int unsigned T_MOSTRA     = 4,
    parameter int unsigned T_INTERVALO  = 2,
    parameter int unsigned T_TIMEOUT    = 20,
    parameter logic [15:0] SEMENTE      = 16'hACE1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic                            modo_grava,
    input  logic [NUM_BOTOES-1:0]           botoes,
    output logic [NUM_BOTOES-1:0]           leds,
    output logic                            pronto,
    output logic                            acertou,
    output logic                            errou,
    output logic                            timeout,
    output logic [$clog2(PROFUNDIDADE)-1:0] rodada,
    output logic [3:0]                      db_estado
);

    localparam int unsigned AW   = $clog2(PROFUNDIDADE);
    localparam int unsigned TM1  = (T_MOSTRA > T_INTERVALO) ? T_MOSTRA : T_INTERVALO;
    localparam int unsigned TMAX = (TM1 > T_TIMEOUT) ? TM1 : T_TIMEOUT;
    localparam int unsigned CW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        StInicial    = 4'd0,
        StPrepara    = 4'd1,
        StGera       = 4'd2,
        StMostraLed  = 4'd3,
        StMostraGap  = 4'd4,
        StEspera     = 4'd5,
        StCompara    = 4'd6,
        StGrava      = 4'd7,
        StProxRodada = 4'd8,
        StFimAcerto  = 4'd9,
        StFimErro    = 4'd10,
        StFimTimeout = 4'd11
    } estado_e;

    estado_e               estado_q, estado_d;
    logic [AW-1:0]         rodada_q, rodada_d;
    logic [AW-1:0]         endereco_q, endereco_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_BOTOES-1:0] jogada_q, jogada_d;
    logic                  modo_q, modo_d;
    logic [15:0]           lfsr_q;
    logic [NUM_BOTOES-1:0] botoes_ant_q;

    logic [NUM_BOTOES-1:0] mem [PROFUNDIDADE];
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [NUM_BOTOES-1:0] mem_wdata;

    logic                  lfsr_fb;
    logic [7:0]            elem_idx;
    logic [NUM_BOTOES-1:0] elem_lfsr;
    logic                  play_evento;
    logic                  play_valido;
    logic                  expira;
    logic                  ultima_rodada;
    logic [AW-1:0]         rodada_inc;

    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign elem_idx  = lfsr_q[7:0] % 8'(NUM_BOTOES);
    assign elem_lfsr = NUM_BOTOES'(1) << elem_idx;

    // Rising edge of "any button": a held button cannot retrigger.
    assign play_evento   = (botoes != '0) && (botoes_ant_q == '0);
    assign play_valido   = $onehot(botoes);
    assign expira        = (cnt_q == CW'(T_TIMEOUT - 1));
    assign ultima_rodada = (rodada_q == AW'(PROFUNDIDADE - 1));
    assign rodada_inc    = ultima_rodada ? rodada_q : rodada_q + AW'(1);

    always_comb begin
        estado_d   = estado_q;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        cnt_d      = '0;
        jogada_d   = jogada_q;
        modo_d     = modo_q;
        mem_we     = 1'b0;
        mem_waddr  = rodada_q;
        mem_wdata  = elem_lfsr;
        leds       = '0;
        case (estado_q)
            StInicial: if (iniciar) estado_d = StPrepara;
            StPrepara: begin
                rodada_d   = '0;
                endereco_d = '0;
                modo_d     = modo_grava;
                estado_d   = StGera;
            end
            StGera: begin
                mem_we   = 1'b1;
                estado_d = StMostraLed;
            end
            StMostraLed: begin
                leds = mem[endereco_q];
                if (cnt_q == CW'(T_MOSTRA - 1)) estado_d = StMostraGap;
                else cnt_d = cnt_q + CW'(1);
            end
            StMostraGap: begin
                if (cnt_q == CW'(T_INTERVALO - 1)) begin
                    if (endereco_q == rodada_q) begin
                        endereco_d = '0;
                        estado_d   = StEspera;
                    end else begin
                        endereco_d = endereco_q + AW'(1);
                        estado_d   = StMostraLed;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // A play in the expiry cycle takes priority over the timeout.
            StEspera: begin
                if (play_evento) begin
                    jogada_d = botoes;
                    estado_d = StCompara;
                end else if (expira) begin
                    estado_d = StFimTimeout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCompara: begin
                if (jogada_q != mem[endereco_q]) begin
                    estado_d = StFimErro;
                end else if (endereco_q < rodada_q) begin
                    endereco_d = endereco_q + AW'(1);
                    estado_d   = StEspera;
                end else if (ultima_rodada) begin
                    estado_d = StFimAcerto;
                end else if (modo_q) begin
                    estado_d = StGrava;
                end else begin
                    estado_d = StProxRodada;
                end
            end
            StGrava: begin
                if (play_evento) begin
                    if (play_valido) begin
                        mem_we     = 1'b1;
                        mem_waddr  = rodada_q + AW'(1);
                        mem_wdata  = botoes;
                        rodada_d   = rodada_inc;
                        endereco_d = '0;
                        estado_d   = StEspera;
                    end else begin
                        estado_d = StFimErro;
                    end
                end else if (expira) begin
                    estado_d = StFimTimeout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StProxRodada: begin
                rodada_d   = rodada_inc;
                endereco_d = '0;
                estado_d   = StGera;
            end
            StFimAcerto, StFimErro, StFimTimeout: if (iniciar) estado_d = StPrepara;
            default: estado_d = StInicial;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= StInicial;
            rodada_q     <= '0;
            endereco_q   <= '0;
            cnt_q        <= '0;
            jogada_q     <= '0;
            modo_q       <= 1'b0;
            lfsr_q       <= SEMENTE;
            botoes_ant_q <= '0;
        end else begin
            estado_q     <= estado_d;
            rodada_q     <= rodada_d;
            endereco_q   <= endereco_d;
            cnt_q        <= cnt_d;
            jogada_q     <= jogada_d;
            modo_q       <= modo_d;
            lfsr_q       <= {lfsr_fb, lfsr_q[15:1]};
            botoes_ant_q <= botoes;
        end
    end

    // Sequence storage is never cleared; each entry is written before it is replayed.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign pronto    = (estado_q == StInicial);
    assign acertou   = (estado_q == StFimAcerto);
    assign errou     = (estado_q == StFimErro);
    assign timeout   = (estado_q == StFimTimeout);
    assign rodada    = rodada_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Directed bench for jogo_sequencia_param: a reference LFSR predicts each generated element,
// scenario tasks drive plays and check states, flags and LED timing cycle by cycle.
module tb_jogo_sequencia_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       modo_grava;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       pronto, acertou, errou, timeout;
    logic [1:0] rodada;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    logic [3:0]  exp_seq [4];

    jogo_sequencia_param #(
        .NUM_BOTOES  (4),
        .PROFUNDIDADE(4),
        .T_MOSTRA    (4),
        .T_INTERVALO (2),
        .T_TIMEOUT   (20),
        .SEMENTE     (16'hACE1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .modo_grava(modo_grava),
        .botoes    (botoes),
        .leds      (leds),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .rodada    (rodada),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Reference Fibonacci LFSR, taps 16,14,13,11, shifting right.
    always @(posedge clock) begin
        if (reset) lfsr_m <= 16'hACE1;
        else lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    function automatic logic [3:0] elem_of(input logic [15:0] m);
        logic [7:0] idx;
        idx = m[7:0] % 8'd4;
        return 4'b0001 << idx[1:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; iniciar = 1'b0; botoes = 4'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Leaves the bench in the first MOSTRA_LED cycle with exp_seq[0] predicted.
    task automatic start_game(input logic modo);
        modo_grava = modo;
        iniciar = 1'b1;
        tick();
        checks++;
        if (db_estado !== 4'd1) begin
            errors++; $display("FAIL start_prepara: db_estado=%0d expected 1", db_estado);
        end
        iniciar = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'd2 || rodada !== 2'd0) begin
            errors++; $display("FAIL start_gera: db_estado=%0d rodada=%0d expected 2/0", db_estado, rodada);
        end
        exp_seq[0] = elem_of(lfsr_m);
        tick();
    endtask

    task automatic play_back(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (db_estado !== 4'd3 || leds !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL playback_lit[%0d.%0d]: state=%0d leds=%b expected 3/%b",
                             i, j, db_estado, leds, exp_seq[i]);
                end
                tick();
            end
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (db_estado !== 4'd4 || leds !== 4'b0) begin
                    errors++;
                    $display("FAIL playback_gap[%0d.%0d]: state=%0d leds=%b expected 4/0000",
                             i, j, db_estado, leds);
                end
                tick();
            end
        end
        checks++;
        if (db_estado !== 4'd5) begin
            errors++; $display("FAIL playback_espera: db_estado=%0d expected 5", db_estado);
        end
    endtask

    // Edge in the current cycle; returns two cycles later with the result visible.
    task automatic press(input logic [3:0] b);
        botoes = b;
        tick();
        checks++;
        if (db_estado !== 4'd6) begin
            errors++; $display("FAIL press_compara: db_estado=%0d expected 6", db_estado);
        end
        botoes = 4'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; modo_grava = 1'b0; botoes = 4'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if ({pronto, acertou, errou, timeout} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got %b expected 1000", {pronto, acertou, errou, timeout});
        end
        checks++;
        if (leds !== 4'b0 || db_estado !== 4'd0 || rodada !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: leds=%b state=%0d rodada=%0d expected 0/0/0", leds, db_estado, rodada);
        end
    endtask

    task automatic test_full_game();
        do_reset();
        start_game(1'b0);
        for (int r = 0; r < 4; r++) begin
            play_back(r + 1);
            for (int i = 0; i <= r; i++) begin
                press(exp_seq[i]);
                if (i < r) begin
                    checks++;
                    if (db_estado !== 4'd5) begin
                        errors++; $display("FAIL game_next_elem[%0d.%0d]: state=%0d expected 5", r, i, db_estado);
                    end
                end else if (r < 3) begin
                    checks++;
                    if (db_estado !== 4'd8) begin
                        errors++; $display("FAIL game_prox[%0d]: state=%0d expected 8", r, db_estado);
                    end
                    tick();
                    checks++;
                    if (db_estado !== 4'd2 || rodada !== 2'(r + 1)) begin
                        errors++;
                        $display("FAIL game_gera[%0d]: state=%0d rodada=%0d expected 2/%0d", r, db_estado, rodada, r + 1);
                    end
                    exp_seq[r + 1] = elem_of(lfsr_m);
                    tick();
                end
            end
        end
        checks++;
        if (db_estado !== 4'd9 || acertou !== 1'b1 || errou !== 1'b0 || rodada !== 2'd3 || leds !== 4'b0) begin
            errors++;
            $display("FAIL game_win: state=%0d acertou=%b errou=%b rodada=%0d leds=%b expected 9/1/0/3/0000",
                     db_estado, acertou, errou, rodada, leds);
        end
        repeat (3) tick();
        checks++;
        if (acertou !== 1'b1 || rodada !== 2'd3) begin
            errors++; $display("FAIL game_win_held: acertou=%b rodada=%0d expected 1/3", acertou, rodada);
        end
    endtask

    task automatic test_wrong_play();
        logic [3:0] wrong;
        do_reset();
        start_game(1'b0);
        play_back(1);
        press(exp_seq[0]);
        tick();
        exp_seq[1] = elem_of(lfsr_m);
        tick();
        play_back(2);
        wrong = {exp_seq[0][2:0], exp_seq[0][3]};
        press(wrong);
        checks++;
        if (db_estado !== 4'd10 || errou !== 1'b1 || leds !== 4'b0) begin
            errors++; $display("FAIL wrong_errou: state=%0d errou=%b leds=%b expected 10/1/0000", db_estado, errou, leds);
        end
        repeat (3) tick();
        checks++;
        if (errou !== 1'b1) begin
            errors++; $display("FAIL wrong_held: errou=%b expected 1", errou);
        end
        start_game(1'b0);
        checks++;
        if (db_estado !== 4'd3 || leds !== exp_seq[0]) begin
            errors++; $display("FAIL restart_lit: state=%0d leds=%b expected 3/%b", db_estado, leds, exp_seq[0]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_game(1'b0);
        play_back(1);
        for (int k = 1; k < 20; k++) begin
            iniciar = (k >= 5 && k < 10);
            tick();
        end
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'd5 || timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_early: state=%0d timeout=%b expected 5/0", db_estado, timeout);
        end
        tick();
        checks++;
        if (db_estado !== 4'd11 || timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_exact: state=%0d timeout=%b expected 11/1", db_estado, timeout);
        end
        start_game(1'b0);
        play_back(1);
        repeat (19) tick();
        press(exp_seq[0]);
        checks++;
        if (db_estado !== 4'd8 || timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_late_play: state=%0d timeout=%b expected 8/0", db_estado, timeout);
        end
    endtask

    task automatic test_multibit();
        do_reset();
        start_game(1'b0);
        play_back(1);
        press(4'b0011);
        checks++;
        if (db_estado !== 4'd10 || errou !== 1'b1) begin
            errors++; $display("FAIL multibit: state=%0d errou=%b expected 10/1", db_estado, errou);
        end
    endtask

    task automatic test_hold();
        do_reset();
        start_game(1'b0);
        repeat (4) tick();
        botoes = exp_seq[0];
        tick(); tick();
        repeat (3) tick();
        checks++;
        if (db_estado !== 4'd5) begin
            errors++; $display("FAIL hold_no_event: state=%0d expected 5", db_estado);
        end
        botoes = 4'b0;
        tick();
        press(exp_seq[0]);
        checks++;
        if (db_estado !== 4'd8) begin
            errors++; $display("FAIL hold_repress: state=%0d expected 8", db_estado);
        end
    endtask

    task automatic test_grava();
        logic [3:0] rec;
        do_reset();
        start_game(1'b1);
        play_back(1);
        press(exp_seq[0]);
        checks++;
        if (db_estado !== 4'd7 || rodada !== 2'd0) begin
            errors++; $display("FAIL grava_enter: state=%0d rodada=%0d expected 7/0", db_estado, rodada);
        end
        rec = (exp_seq[0] == 4'b0100) ? 4'b0010 : 4'b0100;
        botoes = rec;
        tick();
        checks++;
        if (db_estado !== 4'd5 || rodada !== 2'd1 || leds !== 4'b0) begin
            errors++;
            $display("FAIL grava_record: state=%0d rodada=%0d leds=%b expected 5/1/0000", db_estado, rodada, leds);
        end
        botoes = 4'b0;
        tick();
        press(exp_seq[0]);
        checks++;
        if (db_estado !== 4'd5) begin
            errors++; $display("FAIL grava_elem0: state=%0d expected 5", db_estado);
        end
        press(rec);
        checks++;
        if (db_estado !== 4'd7 || rodada !== 2'd1) begin
            errors++; $display("FAIL grava_elem1: state=%0d rodada=%0d expected 7/1", db_estado, rodada);
        end
        botoes = 4'b0011;
        tick();
        checks++;
        if (db_estado !== 4'd10 || errou !== 1'b1) begin
            errors++; $display("FAIL grava_invalid: state=%0d errou=%b expected 10/1", db_estado, errou);
        end
        botoes = 4'b0;
        tick();
        start_game(1'b1);
        play_back(1);
        press(exp_seq[0]);
        botoes = rec;
        tick();
        botoes = 4'b0;
        tick();
        press(rec);
        checks++;
        if (db_estado !== 4'd10 || errou !== 1'b1) begin
            errors++; $display("FAIL grava_order: state=%0d errou=%b expected 10/1", db_estado, errou);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_game(1'b0);
        tick();
        checks++;
        if (leds !== exp_seq[0]) begin
            errors++; $display("FAIL mid_lit: leds=%b expected %b", leds, exp_seq[0]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (leds !== 4'b0 || pronto !== 1'b1 || db_estado !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: leds=%b pronto=%b state=%0d expected 0000/1/0", leds, pronto, db_estado);
        end
    endtask

    initial begin
        test_reset();
        test_full_game();
        test_wrong_play();
        test_timeout();
        test_multibit();
        test_hold();
        test_grava();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jogo_sequencia_param.md
# jogo_sequencia_param

Parametrised sequence-memory game engine: the next generation of the game datapath, with the control FSM folded in. It generalises button/LED count and sequence depth, and adds on-chip pseudo-random sequence generation (16-bit LFSR). It also supports a "record" mode in which the player appends each new element. It sits between the debounced button inputs and the LED/buzzer outputs of the top level, and replaces the separate datapath/control pair.

## Interface
- NUM_BOTOES, 4: number of buttons/LEDs, one-hot element width (2..8)
- PROFUNDIDADE, 16: maximum sequence length (power of 2, ≥2)
- T_MOSTRA, 4: cycles each element is lit during playback
- T_INTERVALO, 2: dark cycles after each lit element
- T_TIMEOUT, 20: cycles allowed per player input
- SEMENTE, 16'hACE1: LFSR reset value (nonzero)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to INICIAL
- iniciar  in  1  start/restart request, sampled in INICIAL and final states
- modo_grava  in  1  0 = all elements from LFSR; 1 = player records elements 1..N; registered on start
- botoes  in  NUM_BOTOES  synchronised button levels
- leds  out  NUM_BOTOES  playback element or 0
- pronto  out  1  high in INICIAL
- acertou / errou / timeout  out  1  each high only in its final state
- rodada  out  $clog2(PROFUNDIDADE)  current round index (round r = r+1 elements)
- db_estado  out  4  FSM state encoding

## Operation
- LFSR: Fibonacci, taps 16,14,13,11. Advances every cycle except under reset. New element = one-hot of (lfsr[7:0] % NUM_BOTOES).
- Memory: PROFUNDIDADE × NUM_BOTOES registers, not cleared by reset; every location is written before it is read.
- Play event: botoes ≠ 0 now and botoes == 0 in the previous cycle. A held button never retriggers. A play is valid only if exactly one bit is set; a multi-bit play counts as wrong.
- FSM states:
  - INICIAL(0): iniciar → PREPARA.
  - PREPARA(1): rodada=0, endereco=0, modo registered → GERA.
  - GERA(2): mem[rodada] ← LFSR element → MOSTRA_LED.
  - MOSTRA_LED(3): leds=mem[endereco] for T_MOSTRA cycles → MOSTRA_GAP.
  - MOSTRA_GAP(4): leds=0 for T_INTERVALO cycles. If endereco==rodada, endereco←0 → ESPERA; else endereco++ → MOSTRA_LED.
  - ESPERA(5): timer runs; play event → COMPARA with jogada registered; timer reaching T_TIMEOUT → FIM_TIMEOUT.
  - COMPARA(6), 1 cycle:
    - wrong → FIM_ERRO.
    - correct and endereco<rodada → endereco++, timer cleared → ESPERA.
    - correct and endereco==rodada: rodada==PROFUNDIDADE-1 → FIM_ACERTO; modo_grava=1 → GRAVA; else → PROX_RODADA.
  - GRAVA(7): waits for a valid play with timeout. Valid play → mem[rodada+1] ← play, rodada++, endereco←0 → ESPERA (no playback). Invalid play → FIM_ERRO.
  - PROX_RODADA(8): rodada++, endereco←0 → GERA.
  - FIM_ACERTO(9) / FIM_ERRO(10) / FIM_TIMEOUT(11): flag held, leds=0. iniciar → PREPARA.
- Round 0 is always LFSR-generated and shown, in both modes.

## Timing
- Reset values: leds=0, pronto=1, acertou=errou=timeout=0, rodada=0, db_estado=0, LFSR=SEMENTE, play-edge history=0.
- iniciar sampled at edge e: PREPARA e+1, GERA e+2; leds lit from cycle e+3 for exactly T_MOSTRA cycles.
- Per element: T_MOSTRA+T_INTERVALO cycles. ESPERA is entered the cycle after the last gap cycle.
- Play edge detected in cycle c: COMPARA at c+1; result state (or flag) visible at c+2.
- Timeout: FIM_TIMEOUT is entered exactly T_TIMEOUT cycles after entering ESPERA/GRAVA or after the last accepted play. A play edge in the same cycle as expiry wins.
- iniciar during play states is ignored.
- reset mid-operation: next cycle in INICIAL, leds=0.
- rodada saturates at PROFUNDIDADE-1, with no wrap.

## Test plan
- Reset, then idle 10 cycles → pronto=1, leds=0, all flags 0, db_estado=0.
- NUM_BOTOES=4, PROFUNDIDADE=4, modo 0: bench captures leds during each playback and replays them → acertou=1 after round 3, rodada=3, leds=0.
- Round 1: first play differs from mem[0] → errou=1 two cycles after the edge; iniciar then restarts with lit leds at +3 cycles.
- Enter ESPERA, no input → timeout=1 exactly 20 cycles later. Repeat with a play on cycle 20 → COMPARA, no timeout.
- modo_grava=1: repeat element 0, record 4'b0100 → no playback, ESPERA expects element0 then 4'b0100; pressing 4'b0100 first → errou.
- Press 4'b0011 in ESPERA → errou. Hold a button entering ESPERA → no event until release and repress. Assert reset mid-MOSTRA_LED → next cycle leds=0, pronto=1.
